// File: rtl/mem_io_pkg.sv
// Shared constants for the CPU memory/IO bridge: IO register offsets,
// register bit positions and the default base of the IO window.
package mem_io_pkg;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FC00;

  // Register offsets relative to the IO base
  localparam logic [7:0] OFF_LED    = 8'h60;
  localparam logic [7:0] OFF_SW     = 8'h70;
  localparam logic [7:0] OFF_IDX    = 8'h74;
  localparam logic [7:0] OFF_STATUS = 8'h78;
  localparam logic [7:0] OFF_CTRL   = 8'h7C;

  // STATUS and CTRL bit positions
  localparam int STATUS_PEND_BIT = 0;
  localparam int STATUS_OVR_BIT  = 1;
  localparam int CTRL_SEXT_BIT   = 0;

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchroniser followed by a stability counter. The debounced level
// follows the synced input only after it has differed for DEBOUNCE_CYCLES
// consecutive cycles. 'rise' is high during the cycle whose edge takes the
// level from 0 to 1, so a consumer sees the press on that same edge.
module input_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_q;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             settle;

  assign differ = (sync_q != level);
  assign settle = differ && (cnt == CNT_LAST);
  assign rise   = settle && sync_q;

  // Synchronise the raw input and track how long it has disagreed with the level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      cnt       <= '0;
      level     <= 1'b0;
    end else begin
      sync_meta <= raw_in;
      sync_q    <= sync_meta;
      if (settle) begin
        level <= sync_q;
        cnt   <= '0;
      end else if (differ) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_io_bridge.sv
// Bridge between the single-cycle CPU datapath and Data-Memory / board IO.
// Addresses at or above IO_BASE hit the IO register window; everything else
// passes straight through to memory. Loads are fully combinational.
module mem_io_bridge
  import mem_io_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int SW_W            = 8,
  parameter int IDX_W           = 3,
  parameter int LED_W           = 16,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter logic [DATA_W-1:0] IO_BASE = DATA_W'(IO_BASE_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic [DATA_W-1:0] rdata_out,
  output logic [DATA_W-1:0] m_addr,
  output logic              m_re,
  output logic              m_we,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [SW_W-1:0]   sw_in,
  input  logic [IDX_W-1:0]  idx_in,
  input  logic              confirm_in,
  output logic [LED_W-1:0]  led_out
);

  logic              is_io;
  logic [DATA_W-1:0] io_off;
  logic              status_rd;
  logic [SW_W-1:0]   sw_meta, sw_sync;
  logic [IDX_W-1:0]  idx_meta, idx_sync;
  logic              sext;
  logic              pending;
  logic              overrun;
  logic              confirm_level;
  logic              confirm_rise;

  assign is_io     = (addr_in >= IO_BASE);
  assign io_off    = addr_in - IO_BASE;
  assign m_addr    = addr_in;
  assign m_wdata   = wdata_in;
  assign m_re      = cpu_read  && !is_io;
  assign m_we      = cpu_write && !is_io;
  assign status_rd = cpu_read && is_io && (io_off == DATA_W'(OFF_STATUS));

  // Synchronise the switch banks into the clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      idx_meta <= '0;
      idx_sync <= '0;
    end else begin
      sw_meta  <= sw_in;
      sw_sync  <= sw_meta;
      idx_meta <= idx_in;
      idx_sync <= idx_meta;
    end
  end

  input_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_confirm (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_in(confirm_in),
    .level (confirm_level),
    .rise  (confirm_rise)
  );

  // A press can only come out of the released level
  assert property (@(posedge clk) disable iff (!rst_n) confirm_rise |-> !confirm_level);

  // Writable IO registers; writes to other IO offsets are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_out <= '0;
      sext    <= 1'b0;
    end else if (cpu_write && is_io) begin
      if (io_off == DATA_W'(OFF_LED))  led_out <= wdata_in[LED_W-1:0];
      if (io_off == DATA_W'(OFF_CTRL)) sext    <= wdata_in[CTRL_SEXT_BIT];
    end
  end

  // Sticky press flags; a press landing on a STATUS read survives the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else if (status_rd) begin
      pending <= confirm_rise;
      overrun <= 1'b0;
    end else if (confirm_rise) begin
      if (pending) overrun <= 1'b1;
      pending <= 1'b1;
    end
  end

  // Load data mux: memory, IO register, or 0 when no load is in progress
  always_comb begin
    rdata_out = '0;
    if (cpu_read) begin
      if (!is_io) begin
        rdata_out = m_rdata;
      end else if (io_off == DATA_W'(OFF_LED)) begin
        rdata_out = DATA_W'(led_out);
      end else if (io_off == DATA_W'(OFF_SW)) begin
        rdata_out = {{(DATA_W-SW_W){sext & sw_sync[SW_W-1]}}, sw_sync};
      end else if (io_off == DATA_W'(OFF_IDX)) begin
        rdata_out = DATA_W'(idx_sync);
      end else if (io_off == DATA_W'(OFF_STATUS)) begin
        rdata_out[STATUS_PEND_BIT] = pending;
        rdata_out[STATUS_OVR_BIT]  = overrun;
      end else if (io_off == DATA_W'(OFF_CTRL)) begin
        rdata_out[CTRL_SEXT_BIT] = sext;
      end
    end
  end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Bench for mem_io_bridge: directed walk through the IO map, debounce and
// reset behaviour, then random bus and button traffic against a model.
module tb_mem_io_bridge;

  localparam int          DB      = 4;
  localparam logic [31:0] IO_BASE = 32'hFFFF_FC00;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_read, cpu_write;
  logic [31:0] addr_in, wdata_in, m_rdata;
  logic [31:0] rdata_out, m_addr, m_wdata;
  logic        m_re, m_we;
  logic [7:0]  sw_in;
  logic [2:0]  idx_in;
  logic        confirm_in;
  logic [15:0] led_out;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [15:0] led_m;
  logic        sext_m, pend_m, ovr_m;
  logic [7:0]  sw_s1, sw_s2;
  logic [2:0]  idx_s1, idx_s2;
  logic        cf_s1, cf_s2, lvl_m;
  int          run_m;

  mem_io_bridge #(
    .DATA_W(32), .SW_W(8), .IDX_W(3), .LED_W(16),
    .DEBOUNCE_CYCLES(DB), .IO_BASE(IO_BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .addr_in(addr_in), .wdata_in(wdata_in), .rdata_out(rdata_out),
    .m_addr(m_addr), .m_re(m_re), .m_we(m_we), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .sw_in(sw_in), .idx_in(idx_in),
    .confirm_in(confirm_in), .led_out(led_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    led_m = 0; sext_m = 0; pend_m = 0; ovr_m = 0;
    sw_s1 = 0; sw_s2 = 0; idx_s1 = 0; idx_s2 = 0;
    cf_s1 = 0; cf_s2 = 0; lvl_m = 0; run_m = 0;
  endtask

  function automatic logic [31:0] exp_rdata();
    if (!cpu_read) return 32'h0;
    if (addr_in < IO_BASE) return m_rdata;
    case (addr_in - IO_BASE)
      32'h60:  return {16'h0, led_m};
      32'h70:  return (sext_m && sw_s2[7]) ? (32'hFFFF_FF00 | {24'h0, sw_s2}) : {24'h0, sw_s2};
      32'h74:  return {29'h0, idx_s2};
      32'h78:  return {30'h0, ovr_m, pend_m};
      32'h7C:  return {31'h0, sext_m};
      default: return 32'h0;
    endcase
  endfunction

  // Apply the effect of one rising edge to the model (inputs as seen at the edge)
  task automatic model_edge();
    logic        io;
    logic [31:0] off;
    logic        press;
    io    = (addr_in >= IO_BASE);
    off   = addr_in - IO_BASE;
    press = 1'b0;
    // The button level moves once the synced value has disagreed DB cycles running
    if (cf_s2 != lvl_m) begin
      run_m++;
      if (run_m == DB) begin
        lvl_m = cf_s2;
        run_m = 0;
        press = lvl_m;
      end
    end else begin
      run_m = 0;
    end
    if (cpu_write && io && off == 32'h60) led_m  = wdata_in[15:0];
    if (cpu_write && io && off == 32'h7C) sext_m = wdata_in[0];
    if (cpu_read && io && off == 32'h78) begin
      pend_m = press;
      ovr_m  = 1'b0;
    end else if (press) begin
      if (pend_m) ovr_m = 1'b1;
      pend_m = 1'b1;
    end
    sw_s2 = sw_s1;   sw_s1 = sw_in;
    idx_s2 = idx_s1; idx_s1 = idx_in;
    cf_s2 = cf_s1;   cf_s1 = confirm_in;
  endtask

  // Called at a negedge with inputs set: check combinational outputs, take the edge
  task automatic step();
    logic io;
    #1;
    io = (addr_in >= IO_BASE);
    chk("m_addr", m_addr, addr_in);
    chk("m_wdata", m_wdata, wdata_in);
    chk("m_re", {31'h0, m_re}, {31'h0, cpu_read && !io});
    chk("m_we", {31'h0, m_we}, {31'h0, cpu_write && !io});
    chk("rdata", rdata_out, exp_rdata());
    chk("led", {16'h0, led_out}, {16'h0, led_m});
    @(posedge clk);
    if (rst_n) model_edge();
    else       model_reset();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    cpu_read = 0; cpu_write = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cpu_read = 0; cpu_write = 1; addr_in = a; wdata_in = d;
    step();
    cpu_write = 0;
  endtask

  task automatic rd_expect(input string tag, input logic [31:0] a, input logic [31:0] exp);
    cpu_read = 1; cpu_write = 0; addr_in = a;
    #1 chk(tag, rdata_out, exp);
    step();
    cpu_read = 0;
  endtask

  initial begin
    int hold;
    int sel;
    rst_n = 0; cpu_read = 0; cpu_write = 0; addr_in = 0; wdata_in = 0;
    m_rdata = 32'h1357_9BDF; sw_in = 0; idx_in = 0; confirm_in = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Reset state
    rd_expect("rst_led_rd", IO_BASE + 32'h60, 32'h0);
    rd_expect("rst_status", IO_BASE + 32'h78, 32'h0);
    rd_expect("rst_ctrl",   IO_BASE + 32'h7C, 32'h0);
    chk("rst_led", {16'h0, led_out}, 32'h0);

    // LED write and memory pass-through
    cpu_write = 1; addr_in = IO_BASE + 32'h60; wdata_in = 32'h0000_A5A5;
    #1 chk("io_we_blocked", {31'h0, m_we}, 32'h0);
    step(); cpu_write = 0;
    chk("led_a5a5", {16'h0, led_out}, 32'h0000_A5A5);
    cpu_write = 1; addr_in = 32'h0000_0010; wdata_in = 32'h0000_1234;
    #1 chk("mem_we", {31'h0, m_we}, 32'h1);
    step(); cpu_write = 0;
    chk("led_kept", {16'h0, led_out}, 32'h0000_A5A5);
    rd_expect("mem_read", 32'h0000_0010, 32'h1357_9BDF);

    // Switch read, zero- then sign-extended
    sw_in = 8'h80; idx_in = 3'h5;
    idle(2);
    rd_expect("sw_zext", IO_BASE + 32'h70, 32'h0000_0080);
    rd_expect("idx_rd",  IO_BASE + 32'h74, 32'h0000_0005);
    wr(IO_BASE + 32'h7C, 32'hFFFF_FFFF);
    rd_expect("ctrl_rd", IO_BASE + 32'h7C, 32'h1);
    rd_expect("sw_sext", IO_BASE + 32'h70, 32'hFFFF_FF80);
    wr(IO_BASE + 32'h70, 32'h0);
    rd_expect("unmapped", IO_BASE + 32'h64, 32'h0);

    // Glitch of DB-1 cycles is ignored
    confirm_in = 1; idle(DB - 1);
    confirm_in = 0; idle(8);
    rd_expect("glitch", IO_BASE + 32'h78, 32'h0);

    // Held press: the read on the 6th edge (k+5) coincides with the press
    confirm_in = 1; idle(5);
    rd_expect("press_pre",  IO_BASE + 32'h78, 32'h0);
    rd_expect("press_set",  IO_BASE + 32'h78, 32'h1);
    rd_expect("press_clr",  IO_BASE + 32'h78, 32'h0);

    // Two presses without a read: overrun
    confirm_in = 0; idle(8); confirm_in = 1; idle(8);
    confirm_in = 0; idle(8); confirm_in = 1; idle(8);
    rd_expect("overrun",     IO_BASE + 32'h78, 32'h3);
    rd_expect("overrun_clr", IO_BASE + 32'h78, 32'h0);

    // Press landing on a read with pending already set
    confirm_in = 0; idle(8); confirm_in = 1; idle(8);
    confirm_in = 0; idle(8); confirm_in = 1; idle(5);
    rd_expect("coin_old", IO_BASE + 32'h78, 32'h1);
    rd_expect("coin_new", IO_BASE + 32'h78, 32'h1);
    rd_expect("coin_clr", IO_BASE + 32'h78, 32'h0);

    // Asynchronous reset with pending set and LEDs lit
    confirm_in = 0; idle(8); confirm_in = 1; idle(8);
    #2 rst_n = 0;
    #1 chk("arst_led", {16'h0, led_out}, 32'h0);
    cpu_read = 1; addr_in = IO_BASE + 32'h78;
    #1 chk("arst_status", rdata_out, 32'h0);
    cpu_read = 0;
    model_reset();
    @(negedge clk);
    idle(2);
    rst_n = 1;
    // Button held through reset: press on the DB+2th edge after release
    idle(DB + 1);
    rd_expect("held_pre", IO_BASE + 32'h78, 32'h0);
    rd_expect("held_set", IO_BASE + 32'h78, 32'h1);

    // Random traffic
    hold = 1;
    for (int i = 0; i < 800; i++) begin
      hold--;
      if (hold == 0) begin
        confirm_in = ~confirm_in;
        hold = $urandom_range(1, 9);
      end
      if ($urandom_range(0, 3) == 0) sw_in  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) idx_in = 3'($urandom);
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    addr_in = $urandom & 32'h7FFF_FFFC;
        2:       addr_in = IO_BASE + 32'h60;
        3:       addr_in = IO_BASE + 32'h70;
        4:       addr_in = IO_BASE + 32'h74;
        5, 6:    addr_in = IO_BASE + 32'h78;
        7:       addr_in = IO_BASE + 32'h7C;
        8:       addr_in = IO_BASE + 32'h64;
        default: addr_in = IO_BASE + ($urandom & 32'h3FF);
      endcase
      cpu_read  = ($urandom_range(0, 1) == 1);
      cpu_write = ($urandom_range(0, 2) == 0);
      wdata_in  = $urandom;
      m_rdata   = $urandom;
      step();
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
